pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_stage_reg.sv | 66 ++++++
 tb/tb_pipeline_stage_reg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy count
// Ports: CLK, Reset (sync, active-low), Flush; InValid/InReady/DataInput from the producer;
// OutValid/OutReady/DataOutput to the consumer; Occupancy = number of valid stages.
module pipeline_stage_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [WIDTH-1:0]           DataInput,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [WIDTH-1:0]           DataOutput,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] valid_q, valid_d, adv, load;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OW-1:0]    occ_q, occ_d;
  logic             r, l, xfer_in, xfer_out;
  always_comb begin
    adv = '0;
    load = '0;
    valid_d = '0;
    r = OutReady;
    // ready ripples from the consumer back to stage 0: a full stage is ready only if it drains
    for (int i = DEPTH-1; i >= 0; i--) begin
      adv[i] = valid_q[i] & r;
      r = ~valid_q[i] | adv[i];
    end
    InReady = r & ~Flush;
    xfer_in = InValid & InReady;
    xfer_out = valid_q[DEPTH-1] & OutReady;
    l = xfer_in;
    // l is the "an entry arrives from upstream" flag for stage i
    for (int i = 0; i < DEPTH; i++) begin
      load[i] = l & ~Flush;
      valid_d[i] = ~Flush & (l | (valid_q[i] & ~adv[i]));
      l = adv[i];
    end
    occ_d = Flush ? '0 : occ_q + OW'(xfer_in) - OW'(xfer_out);
  end
  always_comb begin
    data_d[0] = DataInput;
    for (int i = 1; i < DEPTH; i++) data_d[i] = data_q[i-1];
  end
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      valid_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VALUE;
    end else begin
      valid_q <= valid_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) if (load[i]) data_q[i] <= data_d[i];
    end
  end
  assign OutValid = valid_q[DEPTH-1];
  assign DataOutput = data_q[DEPTH-1];
  assign Occupancy = occ_q;
endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: drives DEPTH=3/2/1 instances in parallel against an entry-position reference model
module tb_pipeline_stage_reg;
  localparam logic [7:0] RV = 8'hA5;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic rst_n = 1'b0, flush = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [7:0] din = 8'h00;
  logic a_ir [3];
  logic a_ov [3];
  logic [7:0] a_do [3];
  logic [1:0] a_occ [3];
  logic [1:0] occ3, occ2;
  logic [0:0] occ1;
  always_comb begin
    a_occ[0] = occ3;
    a_occ[1] = occ2;
    a_occ[2] = {1'b0, occ1};
  end
  pipeline_stage_reg #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(RV)) u3 (
    .CLK(CLK), .Reset(rst_n), .Flush(flush), .InValid(iv), .InReady(a_ir[0]), .DataInput(din),
    .OutValid(a_ov[0]), .OutReady(ordy), .DataOutput(a_do[0]), .Occupancy(occ3));
  pipeline_stage_reg #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(RV)) u2 (
    .CLK(CLK), .Reset(rst_n), .Flush(flush), .InValid(iv), .InReady(a_ir[1]), .DataInput(din),
    .OutValid(a_ov[1]), .OutReady(ordy), .DataOutput(a_do[1]), .Occupancy(occ2));
  pipeline_stage_reg #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(RV)) u1 (
    .CLK(CLK), .Reset(rst_n), .Flush(flush), .InValid(iv), .InReady(a_ir[2]), .DataInput(din),
    .OutValid(a_ov[2]), .OutReady(ordy), .DataOutput(a_do[2]), .Occupancy(occ1));
  int vec = 0, errs = 0;
  int dep [3] = '{3, 2, 1};
  int cnt [3] = '{0, 0, 0};
  int pos [3][3];
  int np [3][3];
  logic [7:0] dat [3][3];
  logic [7:0] last [3] = '{RV, RV, RV};
  bit leave [3];
  logic e_ov [3];
  logic e_ir [3];
  logic [7:0] e_do [3];
  logic [1:0] e_occ [3];
  // Model: each instance holds a list of entries (oldest first) with their stage positions.
  // An entry moves up one stage per cycle unless the slot ahead is still occupied after
  // the older entry has moved; the oldest leaves from the last stage when OutReady=1.
  task automatic predict();
    int lim;
    #1;
    for (int k = 0; k < 3; k++) begin
      lim = dep[k] - 1;
      leave[k] = 1'b0;
      for (int i = 0; i < cnt[k]; i++) begin
        if (i == 0 && pos[k][0] == dep[k] - 1 && ordy) begin
          leave[k] = 1'b1;
          np[k][i] = -1;
        end else begin
          np[k][i] = (pos[k][i] + 1 > lim) ? lim : pos[k][i] + 1;
          lim = np[k][i] - 1;
        end
      end
      e_ov[k] = cnt[k] > 0 && pos[k][0] == dep[k] - 1;
      e_do[k] = last[k];
      e_occ[k] = 2'(cnt[k]);
      e_ir[k] = !flush && (cnt[k] == int'(leave[k]) || np[k][cnt[k] - 1] > 0);
    end
  endtask
  task automatic tick();
    int j;
    int p2 [3];
    logic [7:0] d2 [3];
    predict();
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      j = 0;
      if (!rst_n) last[k] = RV;
      else if (!flush) begin
        for (int i = 0; i < cnt[k]; i++) begin
          if (!(i == 0 && leave[k])) begin
            if (np[k][i] == dep[k] - 1 && pos[k][i] != dep[k] - 1) last[k] = dat[k][i];
            p2[j] = np[k][i];
            d2[j] = dat[k][i];
            j++;
          end
        end
        if (iv && e_ir[k]) begin
          p2[j] = 0;
          d2[j] = din;
          if (dep[k] == 1) last[k] = din;
          j++;
        end
      end
      cnt[k] = j;
      for (int i = 0; i < j; i++) begin
        pos[k][i] = p2[i];
        dat[k][i] = d2[i];
      end
    end
    @(negedge CLK);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; iv = 1'b0; ordy = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    tick();
    predict();
    for (int k = 0; k < 3; k++) begin
      vec += 4;
      if (a_ov[k] !== 1'b0) begin errs++; $display("FAIL reset_ov[%0d] got %b exp 0", k, a_ov[k]); end
      if (a_do[k] !== RV) begin errs++; $display("FAIL reset_do[%0d] got %h exp %h", k, a_do[k], RV); end
      if (a_ir[k] !== 1'b1) begin errs++; $display("FAIL reset_ir[%0d] got %b exp 1", k, a_ir[k]); end
      if (a_occ[k] !== 2'd0) begin errs++; $display("FAIL reset_occ[%0d] got %0d exp 0", k, a_occ[k]); end
    end
  endtask
  task automatic test_latency();
    logic [7:0] v [3] = '{8'h11, 8'h22, 8'h33};
    logic exp_ov;
    ordy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      iv = c < 3;
      if (c < 3) din = v[c];
      predict();
      exp_ov = c >= 3 && c <= 5;
      vec += 2;
      if (a_ov[0] !== exp_ov) begin errs++; $display("FAIL lat_ov c=%0d got %b exp %b", c, a_ov[0], exp_ov); end
      if (a_ir[0] !== 1'b1) begin errs++; $display("FAIL lat_ir c=%0d got %b exp 1", c, a_ir[0]); end
      if (exp_ov) begin
        vec++;
        if (a_do[0] !== v[c-3]) begin errs++; $display("FAIL lat_do c=%0d got %h exp %h", c, a_do[0], v[c-3]); end
      end
      tick();
    end
  endtask
  task automatic test_full_stall();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int idx = 0;
    do_reset();
    iv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      din = w[idx];
      predict();
      if (a_ir[0]) idx++;
      tick();
    end
    din = w[3];
    predict();
    vec += 3;
    if (idx !== 3) begin errs++; $display("FAIL stall_accepts got %0d exp 3", idx); end
    if (a_occ[0] !== 2'd3) begin errs++; $display("FAIL stall_occ got %0d exp 3", a_occ[0]); end
    if (a_ir[0] !== 1'b0) begin errs++; $display("FAIL stall_ir got %b exp 0", a_ir[0]); end
    ordy = 1'b1;
    predict();
    vec += 3;
    if (a_ir[0] !== 1'b1) begin errs++; $display("FAIL full_drain_ir got %b exp 1", a_ir[0]); end
    if (a_ov[0] !== 1'b1) begin errs++; $display("FAIL full_drain_ov got %b exp 1", a_ov[0]); end
    if (a_do[0] !== 8'h11) begin errs++; $display("FAIL full_drain_do got %h exp 11", a_do[0]); end
    tick();
    ordy = 1'b0; iv = 1'b0;
    predict();
    vec += 2;
    if (a_occ[0] !== 2'd3) begin errs++; $display("FAIL full_swap_occ got %0d exp 3", a_occ[0]); end
    if (a_do[0] !== 8'h22) begin errs++; $display("FAIL full_swap_do got %h exp 22", a_do[0]); end
  endtask
  task automatic test_flush();
    flush = 1'b1; iv = 1'b1; ordy = 1'b1; din = 8'h55;
    predict();
    vec += 3;
    if (a_ir[0] !== 1'b0) begin errs++; $display("FAIL flush_ir got %b exp 0", a_ir[0]); end
    if (a_ov[0] !== 1'b1) begin errs++; $display("FAIL flush_ov got %b exp 1", a_ov[0]); end
    if (a_do[0] !== 8'h22) begin errs++; $display("FAIL flush_do got %h exp 22", a_do[0]); end
    tick();
    flush = 1'b0; iv = 1'b0;
    predict();
    vec += 3;
    if (a_ov[0] !== 1'b0) begin errs++; $display("FAIL flush_after_ov got %b exp 0", a_ov[0]); end
    if (a_occ[0] !== 2'd0) begin errs++; $display("FAIL flush_after_occ got %0d exp 0", a_occ[0]); end
    if (a_ir[0] !== 1'b1) begin errs++; $display("FAIL flush_after_ir got %b exp 1", a_ir[0]); end
  endtask
  task automatic test_reset_midstream();
    do_reset();
    iv = 1'b1;
    din = 8'h71;
    tick();
    din = 8'h72;
    tick();
    iv = 1'b0;
    predict();
    vec++;
    if (a_occ[0] !== 2'd2) begin errs++; $display("FAIL mid_occ got %0d exp 2", a_occ[0]); end
    rst_n = 1'b0; flush = 1'b1; iv = 1'b1; ordy = 1'b1; din = 8'h73;
    tick();
    rst_n = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0;
    predict();
    vec += 4;
    if (a_ov[0] !== 1'b0) begin errs++; $display("FAIL mid_rst_ov got %b exp 0", a_ov[0]); end
    if (a_do[0] !== RV) begin errs++; $display("FAIL mid_rst_do got %h exp %h", a_do[0], RV); end
    if (a_occ[0] !== 2'd0) begin errs++; $display("FAIL mid_rst_occ got %0d exp 0", a_occ[0]); end
    if (a_ir[0] !== 1'b1) begin errs++; $display("FAIL mid_rst_ir got %b exp 1", a_ir[0]); end
    iv = 1'b1; ordy = 1'b1; din = 8'h66;
    tick();
    iv = 1'b0;
    tick();
    predict();
    vec++;
    if (a_ov[0] !== 1'b0) begin errs++; $display("FAIL post_rst_early_ov got %b exp 0", a_ov[0]); end
    tick();
    predict();
    vec += 2;
    if (a_ov[0] !== 1'b1) begin errs++; $display("FAIL post_rst_ov got %b exp 1", a_ov[0]); end
    if (a_do[0] !== 8'h66) begin errs++; $display("FAIL post_rst_do got %h exp 66", a_do[0]); end
    tick();
  endtask
  task automatic test_depth1();
    logic [7:0] nxt_in = 8'h80, exp_out = 8'h80;
    int n_out = 0;
    do_reset();
    iv = 1'b1;
    for (int c = 0; c < 20; c++) begin
      ordy = c[0];
      din = nxt_in;
      predict();
      if (c >= 1) begin
        vec++;
        if (a_ir[2] !== ordy) begin errs++; $display("FAIL d1_ir c=%0d got %b exp %b", c, a_ir[2], ordy); end
      end
      if (a_ov[2] && ordy) begin
        vec++;
        if (a_do[2] !== exp_out) begin errs++; $display("FAIL d1_data c=%0d got %h exp %h", c, a_do[2], exp_out); end
        exp_out++;
        n_out++;
      end
      if (a_ir[2]) nxt_in++;
      tick();
    end
    vec++;
    if (n_out !== 10) begin errs++; $display("FAIL d1_transfers got %0d exp 10", n_out); end
    iv = 1'b0;
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      iv = 1'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      din = 8'($urandom);
      predict();
      for (int k = 0; k < 3; k++) begin
        vec += 4;
        if (a_ov[k] !== e_ov[k]) begin errs++; $display("FAIL rnd_ov[%0d] c=%0d got %b exp %b", k, c, a_ov[k], e_ov[k]); end
        if (a_ir[k] !== e_ir[k]) begin errs++; $display("FAIL rnd_ir[%0d] c=%0d got %b exp %b", k, c, a_ir[k], e_ir[k]); end
        if (a_do[k] !== e_do[k]) begin errs++; $display("FAIL rnd_do[%0d] c=%0d got %h exp %h", k, c, a_do[k], e_do[k]); end
        if (a_occ[k] !== e_occ[k]) begin errs++; $display("FAIL rnd_occ[%0d] c=%0d got %0d exp %0d", k, c, a_occ[k], e_occ[k]); end
      end
      tick();
    end
    flush = 1'b0;
  endtask
  initial begin
    @(negedge CLK);
    test_reset();
    test_latency();
    test_full_stall();
    test_flush();
    test_reset_midstream();
    test_depth1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
